fetch_stage: RTL
================

Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline: PC register, next-PC selection, instruction memory and the IF/DEC pipeline register.
- Consumes pc_write and if_dec_write from the hazard unit and redirect requests (branch/jump) from decode.
- Feeds decode with the instruction and PC+4, and raises halt when a HALT opcode reaches IF/DEC.
- Instruction memory is loaded by the debug/loader path while the pipeline is disabled.

Parameters:
- NB_DATA, 32, instruction/PC width
- NB_OPCODE, 6, opcode field width
- IMEM_DEPTH, 256, instruction memory depth in words (power of 2)
- NB_ADDR, 8, log2(IMEM_DEPTH)
- HALT_OPCODE, 6'b111111, opcode that stops fetch

Ports:
- clock  in  1  system clock; all state rising-edge
- reset  in  1  asynchronous, active-low reset
- enable_i  in  1  global pipeline enable (debug step/run); 0 freezes all state
- pc_write_i  in  1  from hazard unit; 0 holds PC
- if_dec_write_i  in  1  from hazard unit; 0 holds IF/DEC register
- redirect_i  in  1  decode resolved taken branch/jump
- redirect_pc_i  in  NB_DATA  target byte address
- imem_wr_en_i  in  1  loader write strobe
- imem_wr_addr_i  in  NB_ADDR  loader word address
- imem_wr_data_i  in  NB_DATA  loader word
- pc_o  out  NB_DATA  current PC (byte address)
- if_dec_instr_o  out  NB_DATA  latched instruction to decode
- if_dec_pc_plus4_o  out  NB_DATA  latched PC+4 to decode
- halt_o  out  1  HALT opcode present in IF/DEC (to hazard unit)

Behaviour:
- Reset (reset=0, async): PC=0, if_dec_instr_o=0 (NOP), if_dec_pc_plus4_o=0, halted flag=0, halt_o=0. Memory contents not reset.
- Memory:
  - Word-addressed, index = PC[NB_ADDR+1:2]; higher PC bits are ignored (wrap modulo depth).
  - Asynchronous read; synchronous write on imem_wr_en_i, independent of enable_i.
  - Read-during-write to the same word returns old data.
- Advance: a cycle with enable_i=1 and the update conditions below.
- PC update, priority order:
  - (1) enable_i=0 or pc_write_i=0 or halted: hold. A redirect_i in this cycle is ignored; decode re-presents it after the stall.
  - (2) redirect_i=1: PC<=redirect_pc_i.
  - (3) else PC<=PC+4, 32-bit wrap at 0xFFFFFFFC->0.
- IF/DEC update, priority order:
  - (1) enable_i=0 or if_dec_write_i=0: hold.
  - (2) redirect_i=1: flush. instr<=0, pc_plus4<=0. This squashes the wrong-path instruction; there is no delay slot.
  - (3) halted: instr<=0 (NOP bubbles after HALT), pc_plus4 holds.
  - (4) else instr<=imem[PC], pc_plus4<=PC+4.
- Latency: an instruction at PC appears on if_dec_instr_o one advancing cycle after PC is presented.
- Halt:
  - On the advance that latches an instruction with opcode==HALT_OPCODE, halted<=1 on the same edge.
  - halt_o = (if_dec_instr_o[31:26]==HALT_OPCODE), combinational from the register.
  - halted cleared only by reset. A redirect arriving in the HALT's latch cycle wins, because the flush prevents the HALT from latching.
- Stall + redirect in the same cycle: stall wins on both PC and IF/DEC.
- Reset mid-load: pending write is dropped; memory keeps prior words.

Decomposition:
- Shared package/header: NB_DATA, NB_OPCODE, HALT_OPCODE, NOP encoding (32'h0), opcode field slice constants.
- One sub-module: instruction_memory (depth param, async read, sync write port).
- PC logic, next-PC mux and IF/DEC register stay in fetch_stage.

Test Plan:
- Sequential fetch: load words 0..3 = 0x11,0x22,0x33,0x44, enable=1 -> if_dec_instr_o = 0x11,0x22,0x33 on successive cycles; pc_plus4 = 4,8,12.
- Stall: hold pc_write_i=0 and if_dec_write_i=0 for 2 cycles while PC=8 -> pc_o stays 8, if_dec_instr_o stays 0x22; resumes with 0x33.
- Redirect: redirect_i=1, target=0x40, at PC=12 -> next cycle pc_o=0x40 and if_dec_instr_o=0; following cycle shows imem[16].
- Stall+redirect collision: pc_write_i=0, if_dec_write_i=0, redirect_i=1 -> PC and IF/DEC unchanged; redirect reapplied next cycle takes effect.
- Halt: word 2 = 0xFC000000 -> halt_o=1 after third fetch; PC frozen at 12; later if_dec_instr_o=0 and halt_o drops. Reset restores PC=0.
- Async reset mid-run: drop reset between edges at PC=0x20 -> outputs clear immediately without a clock edge.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared constants for the IF stage: widths, HALT/NOP encodings and opcode field position.
package fetch_stage_pkg;

    localparam int NB_DATA    = 32;
    localparam int NB_OPCODE  = 6;
    localparam int IMEM_DEPTH = 256;
    localparam int NB_ADDR    = 8;

    localparam logic [NB_OPCODE-1:0] HALT_OPCODE = 6'b111111;
    localparam logic [NB_DATA-1:0]   NOP_INSTR   = 32'h0000_0000;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;

    function automatic logic [NB_OPCODE-1:0] opcode_of(input logic [NB_DATA-1:0] instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control, redirect, loader and IF/DEC signals of the fetch stage, bundled for port connection.
interface fetch_stage_if #(
    parameter int NB_DATA = fetch_stage_pkg::NB_DATA,
    parameter int NB_ADDR = fetch_stage_pkg::NB_ADDR
);
    logic               enable_i;
    logic               pc_write_i;
    logic               if_dec_write_i;
    logic               redirect_i;
    logic [NB_DATA-1:0] redirect_pc_i;
    logic               imem_wr_en_i;
    logic [NB_ADDR-1:0] imem_wr_addr_i;
    logic [NB_DATA-1:0] imem_wr_data_i;
    logic [NB_DATA-1:0] pc_o;
    logic [NB_DATA-1:0] if_dec_instr_o;
    logic [NB_DATA-1:0] if_dec_pc_plus4_o;
    logic               halt_o;

    // slave is the fetch stage itself; master is the hazard unit / decode / loader side
    modport slave (
        input  enable_i, pc_write_i, if_dec_write_i, redirect_i, redirect_pc_i,
        input  imem_wr_en_i, imem_wr_addr_i, imem_wr_data_i,
        output pc_o, if_dec_instr_o, if_dec_pc_plus4_o, halt_o
    );

    modport master (
        output enable_i, pc_write_i, if_dec_write_i, redirect_i, redirect_pc_i,
        output imem_wr_en_i, imem_wr_addr_i, imem_wr_data_i,
        input  pc_o, if_dec_instr_o, if_dec_pc_plus4_o, halt_o
    );

endinterface

// File: rtl/fetch_stage_instruction_memory.sv
// Word-addressed instruction RAM: asynchronous read, synchronous loader write, contents not reset.
module instruction_memory #(
    parameter int NB_DATA    = 32,
    parameter int NB_ADDR    = 8,
    parameter int IMEM_DEPTH = 256
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wr_en_i,
    input  logic [NB_ADDR-1:0] wr_addr_i,
    input  logic [NB_DATA-1:0] wr_data_i,
    input  logic [NB_ADDR-1:0] rd_addr_i,
    output logic [NB_DATA-1:0] rd_data_o
);

    logic [NB_DATA-1:0] mem_q [IMEM_DEPTH];

    // A write presented while reset is asserted is dropped; stored words survive reset.
    always_ff @(posedge clock) begin
        if (reset && wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Combinational read sees the pre-edge word, so read-during-write returns old data.
    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/fetch_stage.sv
// MIPS IF stage: PC register, next-PC selection, instruction memory and the IF/DEC register.
module fetch_stage #(
    parameter int                                    NB_DATA     = fetch_stage_pkg::NB_DATA,
    parameter int                                    NB_OPCODE   = fetch_stage_pkg::NB_OPCODE,
    parameter int                                    IMEM_DEPTH  = fetch_stage_pkg::IMEM_DEPTH,
    parameter int                                    NB_ADDR     = fetch_stage_pkg::NB_ADDR,
    parameter logic [fetch_stage_pkg::NB_OPCODE-1:0] HALT_OPCODE = fetch_stage_pkg::HALT_OPCODE
) (
    input  logic          clock,
    input  logic          reset,
    fetch_stage_if.slave  bus
);
    import fetch_stage_pkg::*;

    logic [NB_DATA-1:0] pc_q, pc_d;
    logic [NB_DATA-1:0] instr_q, instr_d;
    logic [NB_DATA-1:0] pc_plus4_q, pc_plus4_d;
    logic               halted_q, halted_d;

    logic [NB_DATA-1:0] pc_plus4;
    logic [NB_DATA-1:0] imem_rd_data;
    logic               pc_adv;
    logic               if_dec_adv;

    instruction_memory #(
        .NB_DATA    (NB_DATA),
        .NB_ADDR    (NB_ADDR),
        .IMEM_DEPTH (IMEM_DEPTH)
    ) u_imem (
        .clock     (clock),
        .reset     (reset),
        .wr_en_i   (bus.imem_wr_en_i),
        .wr_addr_i (bus.imem_wr_addr_i),
        .wr_data_i (bus.imem_wr_data_i),
        .rd_addr_i (pc_q[NB_ADDR+1:2]),
        .rd_data_o (imem_rd_data)
    );

    assign pc_plus4   = pc_q + NB_DATA'(4);
    assign pc_adv     = bus.enable_i && bus.pc_write_i && !halted_q;
    assign if_dec_adv = bus.enable_i && bus.if_dec_write_i;

    always_comb begin
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_plus4_d = pc_plus4_q;
        halted_d   = halted_q;

        // A stalled redirect is simply not taken; decode keeps presenting it.
        if (pc_adv) begin
            pc_d = bus.redirect_i ? bus.redirect_pc_i : pc_plus4;
        end

        if (if_dec_adv) begin
            if (bus.redirect_i) begin
                instr_d    = NOP_INSTR;
                pc_plus4_d = '0;
            end else if (halted_q) begin
                instr_d    = NOP_INSTR;
            end else begin
                instr_d    = imem_rd_data;
                pc_plus4_d = pc_plus4;
                if (opcode_of(imem_rd_data) == HALT_OPCODE) begin
                    halted_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q       <= '0;
            instr_q    <= NOP_INSTR;
            pc_plus4_q <= '0;
            halted_q   <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_plus4_q <= pc_plus4_d;
            halted_q   <= halted_d;
        end
    end

    assign bus.pc_o              = pc_q;
    assign bus.if_dec_instr_o    = instr_q;
    assign bus.if_dec_pc_plus4_o = pc_plus4_q;
    assign bus.halt_o            = (opcode_of(instr_q) == HALT_OPCODE);

endmodule
